// File: rtl/pc_unit_if.sv
// Next-PC operation/condition encodings and the D-stage <-> fetch-PC bus.
// The pc_unit drives the slave side; the D stage and CP0 drive the master side.
package pc_unit_pkg;
    localparam logic [2:0] NPC_OP_NORM = 3'd0;
    localparam logic [2:0] NPC_OP_B    = 3'd1;
    localparam logic [2:0] NPC_OP_J26  = 3'd2;
    localparam logic [2:0] NPC_OP_J32  = 3'd3;

    localparam logic [2:0] NPC_COND_UNCOND = 3'd0;
    localparam logic [2:0] NPC_COND_EQ     = 3'd1;
    localparam logic [2:0] NPC_COND_NE     = 3'd2;
    localparam logic [2:0] NPC_COND_LT     = 3'd3;
    localparam logic [2:0] NPC_COND_GT     = 3'd4;
    localparam logic [2:0] NPC_COND_LE     = 3'd5;
    localparam logic [2:0] NPC_COND_GE     = 3'd6;
endpackage

interface pc_unit_if;
    logic        stall;
    logic [2:0]  npc_op;
    logic [2:0]  npc_cond;
    logic        eq;
    logic        lt;
    logic [31:0] d_pc;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] imm32;
    logic        enter_handler;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic        f_bd;
    logic        d_kill;
    logic        f_adel;

    modport master (
        output stall, npc_op, npc_cond, eq, lt, d_pc, imm16, imm26, imm32,
               enter_handler, eret, epc,
        input  pc, f_bd, d_kill, f_adel
    );

    modport slave (
        input  stall, npc_op, npc_cond, eq, lt, d_pc, imm16, imm26, imm32,
               enter_handler, eret, epc,
        output pc, f_bd, d_kill, f_adel
    );
endinterface

// File: rtl/pc_unit.sv
// F-stage program counter: next-PC selection, delay-slot tracking and eret squash.
// Optional fetch address-error detection is enabled by defining PC_ADEL_EN.
module pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE    = 32'h0000_4000
) (
    input  logic      clk,
    input  logic      reset,
    pc_unit_if.slave  pc_if
);
    import pc_unit_pkg::*;

    typedef enum logic {
        S_RUN,
        S_KILL
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        f_bd_q, f_bd_d;

    logic [31:0] seq_target;
    logic [31:0] b_target;
    logic [31:0] j26_target;
    logic [31:0] redirect_target;
    logic        taken;

    assign seq_target = pc_q + 32'd4;
    assign b_target   = pc_if.d_pc + 32'd4 + {{14{pc_if.imm16[15]}}, pc_if.imm16, 2'b00};
    assign j26_target = {pc_if.d_pc[31:28], pc_if.imm26, 2'b00};

    // Undefined condition encodings fall into the ge arm.
    always_comb begin
        case (pc_if.npc_cond)
            NPC_COND_UNCOND: taken = 1'b1;
            NPC_COND_EQ:     taken = pc_if.eq;
            NPC_COND_NE:     taken = !pc_if.eq;
            NPC_COND_LT:     taken = pc_if.lt;
            NPC_COND_GT:     taken = !pc_if.eq && !pc_if.lt;
            NPC_COND_LE:     taken = pc_if.lt || pc_if.eq;
            default:         taken = !pc_if.lt;
        endcase
    end

    // Unknown op encodings still mark a delay slot but have no target of their own.
    always_comb begin
        case (pc_if.npc_op)
            NPC_OP_B:   redirect_target = taken ? b_target     : seq_target;
            NPC_OP_J26: redirect_target = taken ? j26_target   : seq_target;
            NPC_OP_J32: redirect_target = taken ? pc_if.imm32  : seq_target;
            default:    redirect_target = seq_target;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        pc_d    = pc_q;
        f_bd_d  = f_bd_q;
        state_d = state_q;

        if (pc_if.enter_handler) begin
            pc_d    = HANDLER_PC;
            f_bd_d  = 1'b0;
            state_d = S_RUN;
        end else if (pc_if.stall) begin
            pc_d    = pc_q;
        end else if (state_q == S_KILL) begin
            // The instruction now in D is the squashed one; its controls are ignored.
            pc_d    = seq_target;
            f_bd_d  = 1'b0;
            state_d = S_RUN;
        end else if (pc_if.eret) begin
            pc_d    = pc_if.epc;
            f_bd_d  = 1'b0;
            state_d = S_KILL;
        end else if (pc_if.npc_op != NPC_OP_NORM) begin
            pc_d    = redirect_target;
            f_bd_d  = 1'b1;
        end else begin
            pc_d    = seq_target;
            f_bd_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            f_bd_q  <= 1'b0;
            state_q <= S_RUN;
        end else begin
            pc_q    <= pc_d;
            f_bd_q  <= f_bd_d;
            state_q <= state_d;
        end
    end

    assign pc_if.pc     = pc_q;
    assign pc_if.f_bd   = f_bd_q;
    assign pc_if.d_kill = (state_q == S_KILL);

`ifdef PC_ADEL_EN
    // Window end is computed in 33 bits so a window touching 2^32 does not wrap.
    logic [32:0] im_end;
    assign im_end       = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
    assign pc_if.f_adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || ({1'b0, pc_q} >= im_end);
`else
    logic unused_cfg;
    assign unused_cfg   = ^{IM_BASE, IM_SIZE};
    assign pc_if.f_adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vectors plus a cycle-level reference model.
module tb_pc_unit;
    import pc_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    pc_unit_if bus ();

    pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .pc_if (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural pc, delay-slot flag and a pending-squash flag.
    logic [31:0] m_pc;
    logic        m_bd;
    logic        m_kill;
    bit          m_valid = 1'b0;

    function automatic bit m_taken(input logic [2:0] cond, input logic e, input logic l);
        case (cond)
            3'd0:    return 1'b1;
            3'd1:    return e;
            3'd2:    return !e;
            3'd3:    return l;
            3'd4:    return !e && !l;
            3'd5:    return l || e;
            default: return !l;
        endcase
    endfunction

    function automatic logic m_adel(input logic [31:0] p);
`ifdef PC_ADEL_EN
        return (p % 4 != 0) || (p < 32'h3000) || (p >= 32'h7000);
`else
        return (p == p) ? 1'b0 : 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        logic [31:0] tgt;
        if (reset) begin
            m_pc = 32'h3000; m_bd = 1'b0; m_kill = 1'b0;
            m_valid = 1'b1;
        end else if (bus.enter_handler) begin
            m_pc = 32'h4180; m_bd = 1'b0; m_kill = 1'b0;
        end else if (bus.stall) begin
            // everything holds
        end else if (m_kill) begin
            m_pc = m_pc + 4; m_bd = 1'b0; m_kill = 1'b0;
        end else if (bus.eret) begin
            m_pc = bus.epc; m_bd = 1'b0; m_kill = 1'b1;
        end else if (bus.npc_op != 3'd0) begin
            case (bus.npc_op)
                3'd1:    tgt = 32'(bus.d_pc + 32'd4 + 32'(int'($signed(bus.imm16)) * 4));
                3'd2:    tgt = (bus.d_pc & 32'hF000_0000) | (32'(bus.imm26) * 4);
                3'd3:    tgt = bus.imm32;
                default: tgt = m_pc + 4;
            endcase
            m_pc = m_taken(bus.npc_cond, bus.eq, bus.lt) ? tgt : m_pc + 4;
            m_bd = 1'b1;
        end else begin
            m_pc = m_pc + 4; m_bd = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pc", bus.pc, m_pc);
            check("model_f_bd", 32'(bus.f_bd), 32'(m_bd));
            check("model_d_kill", 32'(bus.d_kill), 32'(m_kill));
            check("model_f_adel", 32'(bus.f_adel), 32'(m_adel(m_pc)));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        bus.stall = 1'b0; bus.npc_op = NPC_OP_NORM; bus.npc_cond = NPC_COND_UNCOND;
        bus.eq = 1'b0; bus.lt = 1'b0; bus.eret = 1'b0; bus.enter_handler = 1'b0;
    endtask

    task automatic branch(input logic [2:0] op, input logic [2:0] cond);
        bus.npc_op = op; bus.npc_cond = cond;
    endtask

    // Taken masks over (eq,lt) combos {lt=1, eq=1, neither}, indexed by condition.
    logic [2:0] taken_tbl [8] = '{3'b111, 3'b010, 3'b101, 3'b100,
                                  3'b001, 3'b110, 3'b011, 3'b011};

    initial begin
        logic [31:0] hold_pc;
        clear_d();
        bus.d_pc = '0; bus.imm16 = '0; bus.imm26 = '0; bus.imm32 = '0; bus.epc = '0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;

        // Reset state and sequential fetch
        check("reset_pc", bus.pc, 32'h3000);
        check("reset_f_bd", 32'(bus.f_bd), 32'd0);
        check("reset_d_kill", 32'(bus.d_kill), 32'd0);
        step(); check("seq_pc1", bus.pc, 32'h3004);
        step(); check("seq_pc2", bus.pc, 32'h3008);
`ifndef PC_ADEL_EN
        check("adel_off", 32'(bus.f_adel), 32'd0);
`endif

        // beq taken backwards, then not taken
        branch(NPC_OP_B, NPC_COND_EQ); bus.d_pc = 32'h3010; bus.imm16 = 16'hFFFC; bus.eq = 1'b1;
        step(); check("beq_taken_pc", bus.pc, 32'h3004); check("beq_taken_bd", 32'(bus.f_bd), 32'd1);
        clear_d(); step(); check("after_beq_pc", bus.pc, 32'h3008); check("after_beq_bd", 32'(bus.f_bd), 32'd0);
        branch(NPC_OP_B, NPC_COND_EQ); bus.eq = 1'b0;
        step(); check("beq_nt_pc", bus.pc, 32'h300C); check("beq_nt_bd", 32'(bus.f_bd), 32'd1);
        clear_d(); step();

        // j32 held off by stall
        hold_pc = bus.pc;
        branch(NPC_OP_J32, NPC_COND_UNCOND); bus.imm32 = 32'h3400; bus.stall = 1'b1;
        step(3); check("stall_hold_pc", bus.pc, hold_pc);
        bus.stall = 1'b0;
        step(); check("j32_pc", bus.pc, 32'h3400); check("j32_bd", 32'(bus.f_bd), 32'd1);
        clear_d(); step(); check("after_j32_pc", bus.pc, 32'h3404);

        // j26 keeps the D-stage region bits
        branch(NPC_OP_J26, NPC_COND_UNCOND); bus.d_pc = 32'hA000_1000; bus.imm26 = 26'h0000C00;
        step(); check("j26_pc", bus.pc, 32'hA000_3000);
        clear_d();

        // eret: one squash cycle; D controls ignored while squashing
        branch(NPC_OP_J32, NPC_COND_UNCOND); bus.imm32 = 32'h3050; step(); clear_d();
        bus.eret = 1'b1; bus.epc = 32'h3020;
        step(); check("eret_pc", bus.pc, 32'h3020); check("eret_kill", 32'(bus.d_kill), 32'd1);
        check("eret_bd", 32'(bus.f_bd), 32'd0);
        branch(NPC_OP_J32, NPC_COND_UNCOND); bus.imm32 = 32'h5000;
        step(); check("kill_seq_pc", bus.pc, 32'h3024); check("kill_drop", 32'(bus.d_kill), 32'd0);
        clear_d(); step(); check("post_kill_pc", bus.pc, 32'h3028);

        // eret with stall during the squash cycle
        bus.eret = 1'b1; step(); clear_d(); bus.stall = 1'b1;
        step(2); check("kill_stall_pc", bus.pc, 32'h3020); check("kill_stall_kill", 32'(bus.d_kill), 32'd1);
        bus.stall = 1'b0;
        step(); check("kill_release_pc", bus.pc, 32'h3024); check("kill_release_kill", 32'(bus.d_kill), 32'd0);

        // Handler entry beats stall and a taken branch, and clears f_bd
        branch(NPC_OP_J32, NPC_COND_UNCOND); bus.imm32 = 32'h3300; step();
        bus.stall = 1'b1; bus.enter_handler = 1'b1; bus.imm32 = 32'h3500;
        step(); check("handler_pc", bus.pc, 32'h4180); check("handler_bd", 32'(bus.f_bd), 32'd0);
        check("handler_kill", 32'(bus.d_kill), 32'd0);
        clear_d(); step(); check("handler_seq", bus.pc, 32'h4184);

        // Handler entry during the squash cycle
        bus.eret = 1'b1; bus.epc = 32'h3020; step(); clear_d();
        check("pre_handler_kill", 32'(bus.d_kill), 32'd1);
        bus.enter_handler = 1'b1;
        step(); check("handler_in_kill_pc", bus.pc, 32'h4180); check("handler_in_kill", 32'(bus.d_kill), 32'd0);
        clear_d(); step(); check("handler_in_kill_seq", bus.pc, 32'h4184);

        // All conditions (including undefined encoding 7) against three compare outcomes
        bus.d_pc = 32'h3100; bus.imm16 = 16'h0010;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 3; k++) begin
                hold_pc = bus.pc;
                branch(NPC_OP_B, 3'(c)); bus.eq = (k == 1); bus.lt = (k == 2);
                step();
                check($sformatf("cond%0d_k%0d", c, k), bus.pc,
                      taken_tbl[c][k] ? 32'h3144 : hold_pc + 32'd4);
                clear_d();
            end
        end

`ifdef PC_ADEL_EN
        branch(NPC_OP_J32, NPC_COND_UNCOND); bus.imm32 = 32'h3002;
        step(); check("adel_misalign", 32'(bus.f_adel), 32'd1); check("adel_misalign_pc", bus.pc, 32'h3002);
        bus.imm32 = 32'h7000;
        step(); check("adel_high", 32'(bus.f_adel), 32'd1);
        bus.imm32 = 32'h3004;
        step(); check("adel_ok", 32'(bus.f_adel), 32'd0);
        clear_d();
`endif

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
